// File: rtl/rotate_pkg.sv
// Shared types and constants for the tile-based frame rotation sequencer.
package rotate_pkg;

    localparam int unsigned C_TILE    = 8;
    localparam int unsigned C_BPP     = 3;
    localparam int unsigned P_DIM_W   = 16;
    localparam int unsigned P_LEN_W   = 4;
    localparam int unsigned P_CYC_W   = 32;

    localparam logic [1:0] P_DEG_0   = 2'd0;
    localparam logic [1:0] P_DEG_90  = 2'd1;
    localparam logic [1:0] P_DEG_180 = 2'd2;
    localparam logic [1:0] P_DEG_270 = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_CALC, S_RD_REQ, S_RD_WAIT, S_ROT, S_WR_REQ, S_WR_WAIT, S_NEXT
    } state_e;

    typedef struct packed {
        logic [P_DIM_W-1:0] width;
        logic [P_DIM_W-1:0] height;
        logic [1:0]         degrees;
        logic               ccw;
    } geom_t;

    // Counter-clockwise quarter turns are the opposite clockwise quarter turns.
    function automatic logic [1:0] eff_deg(input logic [1:0] deg, input logic ccw);
        return (ccw && deg[0]) ? (deg ^ 2'd2) : deg;
    endfunction

endpackage

// File: rtl/rotate_tile_ctrl_if.sv
// Config, DMA command and core handshake bundle for rotate_tile_ctrl.
interface rotate_tile_ctrl_if #(parameter int unsigned P_AW = 32);
    logic              I_TC_START;
    logic              I_TC_STOP;
    logic [15:0]       I_TC_WIDTH;
    logic [15:0]       I_TC_HEIGHT;
    logic [1:0]        I_TC_DEGREES;
    logic              I_TC_DIRECTION;
    logic [P_AW-1:0]   I_TC_SRC_BASE;
    logic [P_AW-1:0]   I_TC_DST_BASE;
    logic              O_TC_DMA_REQ;
    logic              O_TC_DMA_WRITE;
    logic [P_AW-1:0]   O_TC_DMA_ADDR;
    logic [3:0]        O_TC_DMA_LEN;
    logic              I_TC_DMA_ACK;
    logic              I_TC_DMA_DONE;
    logic              O_TC_CORE_GO;
    logic              I_TC_CORE_DONE;
    logic              O_TC_BUSY;
    logic              O_TC_DONE;
    logic              O_TC_ERR;
    logic              O_TC_ABORTED;
    logic [31:0]       O_TC_CYCLES;

    modport master (
        input  I_TC_START, I_TC_STOP, I_TC_WIDTH, I_TC_HEIGHT, I_TC_DEGREES, I_TC_DIRECTION,
               I_TC_SRC_BASE, I_TC_DST_BASE, I_TC_DMA_ACK, I_TC_DMA_DONE, I_TC_CORE_DONE,
        output O_TC_DMA_REQ, O_TC_DMA_WRITE, O_TC_DMA_ADDR, O_TC_DMA_LEN, O_TC_CORE_GO,
               O_TC_BUSY, O_TC_DONE, O_TC_ERR, O_TC_ABORTED, O_TC_CYCLES
    );

    modport slave (
        output I_TC_START, I_TC_STOP, I_TC_WIDTH, I_TC_HEIGHT, I_TC_DEGREES, I_TC_DIRECTION,
               I_TC_SRC_BASE, I_TC_DST_BASE, I_TC_DMA_ACK, I_TC_DMA_DONE, I_TC_CORE_DONE,
        input  O_TC_DMA_REQ, O_TC_DMA_WRITE, O_TC_DMA_ADDR, O_TC_DMA_LEN, O_TC_CORE_GO,
               O_TC_BUSY, O_TC_DONE, O_TC_ERR, O_TC_ABORTED, O_TC_CYCLES
    );
endinterface

// File: rtl/rotate_tile_addr.sv
// Combinational source/destination tile mapping and row-0 byte addresses.
module rotate_tile_addr
    import rotate_pkg::*;
#(
    parameter int unsigned P_AW = 32
) (
    input  logic [P_AW-1:0]    src_base_i,
    input  logic [P_AW-1:0]    dst_base_i,
    input  geom_t              geom_i,
    input  logic [P_DIM_W-1:0] tx_i,
    input  logic [P_DIM_W-1:0] ty_i,
    input  logic [P_DIM_W-1:0] ntx_i,
    input  logic [P_DIM_W-1:0] nty_i,
    output logic [P_AW-1:0]    src_row0_c_o,
    output logic [P_AW-1:0]    dst_row0_c_o,
    output logic [P_AW-1:0]    src_stride_c_o,
    output logic [P_AW-1:0]    dst_stride_c_o
);

    logic [1:0]         deg;
    logic [P_DIM_W-1:0] dtx;
    logic [P_DIM_W-1:0] dty;
    logic [P_AW-1:0]    sw;
    logic [P_AW-1:0]    dw;

    always_comb begin
        deg = eff_deg(geom_i.degrees, geom_i.ccw);
        dtx = tx_i;
        dty = ty_i;
        sw  = P_AW'(geom_i.width);
        dw  = P_AW'(geom_i.width);
        case (deg)
            P_DEG_180: begin
                dtx = ntx_i - tx_i - P_DIM_W'(1);
                dty = nty_i - ty_i - P_DIM_W'(1);
            end
            P_DEG_90: begin
                dtx = nty_i - ty_i - P_DIM_W'(1);
                dty = tx_i;
                dw  = P_AW'(geom_i.height);
            end
            P_DEG_270: begin
                dtx = ty_i;
                dty = ntx_i - tx_i - P_DIM_W'(1);
                dw  = P_AW'(geom_i.height);
            end
            default: ;
        endcase
    end

    // Pixel offsets are scaled to bytes last; everything wraps modulo 2^P_AW.
    assign src_row0_c_o   = src_base_i + P_AW'(C_BPP) *
                            (P_AW'(ty_i) * P_AW'(C_TILE) * sw + P_AW'(tx_i) * P_AW'(C_TILE));
    assign dst_row0_c_o   = dst_base_i + P_AW'(C_BPP) *
                            (P_AW'(dty) * P_AW'(C_TILE) * dw + P_AW'(dtx) * P_AW'(C_TILE));
    assign src_stride_c_o = P_AW'(C_BPP) * sw;
    assign dst_stride_c_o = P_AW'(C_BPP) * dw;

endmodule

// File: rtl/rotate_tile_ctrl.sv
// Frame sequencer: per 8x8 tile, 8 row reads, core rotate, 8 row writes.
// Optional busy-cycle counter enabled by defining TC_PERF_CNT_EN.
module rotate_tile_ctrl
    import rotate_pkg::*;
#(
    parameter int unsigned P_AW        = 32,
    parameter int unsigned P_ROW_WORDS = 6
) (
    input  logic               I_TC_HCLK,
    input  logic               I_TC_HRESET_N,
    rotate_tile_ctrl_if.master bus
);

    state_e             state_q, state_d;
    geom_t              geom_q, geom_d;
    logic [P_AW-1:0]    src_base_q, src_base_d, dst_base_q, dst_base_d;
    logic [P_DIM_W-1:0] tx_q, tx_d, ty_q, ty_d, ntx_q, ntx_d, nty_q, nty_d;
    logic [2:0]         row_q, row_d;
    logic               pend_q, pend_d;
    logic               req_q, req_d, wr_q, wr_d, go_q, go_d, busy_q, busy_d;
    logic               done_q, done_d, err_q, err_d, abort_q, abort_d;
    logic [P_AW-1:0]    addr_q, addr_d;
    logic [P_LEN_W-1:0] len_q;
    logic [P_AW-1:0]    src_row0_c, dst_row0_c, src_stride_c, dst_stride_c;
    logic               bad_geom_c, stop_c;

    rotate_tile_addr #(.P_AW(P_AW)) u_addr (
        .src_base_i     (src_base_q),
        .dst_base_i     (dst_base_q),
        .geom_i         (geom_q),
        .tx_i           (tx_q),
        .ty_i           (ty_q),
        .ntx_i          (ntx_q),
        .nty_i          (nty_q),
        .src_row0_c_o   (src_row0_c),
        .dst_row0_c_o   (dst_row0_c),
        .src_stride_c_o (src_stride_c),
        .dst_stride_c_o (dst_stride_c)
    );

    assign stop_c     = bus.I_TC_STOP;
    assign bad_geom_c = (bus.I_TC_WIDTH == '0) || (bus.I_TC_HEIGHT == '0) ||
                        (|bus.I_TC_WIDTH[2:0]) || (|bus.I_TC_HEIGHT[2:0]);

    always_ff @(posedge I_TC_HCLK or negedge I_TC_HRESET_N) begin
        if (!I_TC_HRESET_N) begin
            state_q <= S_IDLE;   geom_q <= '0;     src_base_q <= '0;  dst_base_q <= '0;
            tx_q <= '0; ty_q <= '0; ntx_q <= '0; nty_q <= '0;   row_q <= '0;  pend_q <= 1'b0;
            req_q <= 1'b0; wr_q <= 1'b0; go_q <= 1'b0; busy_q <= 1'b0;
            done_q <= 1'b0; err_q <= 1'b0; abort_q <= 1'b0; addr_q <= '0; len_q <= '0;
        end else begin
            state_q <= state_d;  geom_q <= geom_d; src_base_q <= src_base_d; dst_base_q <= dst_base_d;
            tx_q <= tx_d; ty_q <= ty_d; ntx_q <= ntx_d; nty_q <= nty_d; row_q <= row_d; pend_q <= pend_d;
            req_q <= req_d; wr_q <= wr_d; go_q <= go_d; busy_q <= busy_d;
            done_q <= done_d; err_q <= err_d; abort_q <= abort_d; addr_q <= addr_d;
            len_q <= P_LEN_W'(P_ROW_WORDS);
        end
    end

    always_comb begin
        state_d = state_q;  geom_d = geom_q;  src_base_d = src_base_q;  dst_base_d = dst_base_q;
        tx_d = tx_q; ty_d = ty_q; ntx_d = ntx_q; nty_d = nty_q; row_d = row_q; pend_d = pend_q;
        go_d = 1'b0; done_d = done_q; err_d = err_q; abort_d = abort_q; addr_d = addr_q;

        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (bus.I_TC_START) begin
                    done_d = 1'b0; err_d = 1'b0; abort_d = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bad_geom_c) begin
                    err_d = 1'b1; state_d = S_IDLE;
                end else if (stop_c) begin
                    abort_d = 1'b1; state_d = S_IDLE;
                end else begin
                    geom_d.width = bus.I_TC_WIDTH;   geom_d.height = bus.I_TC_HEIGHT;
                    geom_d.degrees = bus.I_TC_DEGREES; geom_d.ccw = bus.I_TC_DIRECTION;
                    src_base_d = bus.I_TC_SRC_BASE;  dst_base_d = bus.I_TC_DST_BASE;
                    ntx_d = bus.I_TC_WIDTH >> 3;     nty_d = bus.I_TC_HEIGHT >> 3;
                    tx_d = '0; ty_d = '0; row_d = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (stop_c) begin
                    abort_d = 1'b1; state_d = S_IDLE;
                end else begin
                    addr_d = src_row0_c; state_d = S_RD_REQ;
                end
            end
            S_RD_REQ, S_WR_REQ: begin
                // An accepted command must complete even if STOP arrives with the ACK.
                if (bus.I_TC_DMA_ACK) begin
                    pend_d  = stop_c;
                    state_d = (state_q == S_RD_REQ) ? S_RD_WAIT : S_WR_WAIT;
                end else if (stop_c) begin
                    abort_d = 1'b1; state_d = S_IDLE;
                end
            end
            S_RD_WAIT, S_WR_WAIT: begin
                if (bus.I_TC_DMA_DONE) begin
                    if (stop_c || pend_q) begin
                        abort_d = 1'b1; state_d = S_IDLE;
                    end else if (row_q == 3'd7) begin
                        row_d = '0;
                        if (state_q == S_RD_WAIT) begin
                            go_d = 1'b1; addr_d = dst_row0_c; state_d = S_ROT;
                        end else begin
                            state_d = S_NEXT;
                        end
                    end else begin
                        row_d = row_q + 3'd1;
                        if (state_q == S_RD_WAIT) begin
                            addr_d = addr_q + src_stride_c; state_d = S_RD_REQ;
                        end else begin
                            addr_d = addr_q + dst_stride_c; state_d = S_WR_REQ;
                        end
                    end
                end else if (stop_c) begin
                    pend_d = 1'b1;
                end
            end
            S_ROT: begin
                if (bus.I_TC_CORE_DONE) begin
                    if (stop_c || pend_q) begin
                        abort_d = 1'b1; state_d = S_IDLE;
                    end else begin
                        state_d = S_WR_REQ;
                    end
                end else if (stop_c) begin
                    pend_d = 1'b1;
                end
            end
            S_NEXT: begin
                // Completion of the last tile takes priority over a late STOP.
                if ((tx_q + P_DIM_W'(1) == ntx_q) && (ty_q + P_DIM_W'(1) == nty_q)) begin
                    tx_d = '0; ty_d = '0; done_d = 1'b1; state_d = S_IDLE;
                end else if (stop_c) begin
                    abort_d = 1'b1; state_d = S_IDLE;
                end else if (tx_q + P_DIM_W'(1) == ntx_q) begin
                    tx_d = '0; ty_d = ty_q + P_DIM_W'(1); state_d = S_CALC;
                end else begin
                    tx_d = tx_q + P_DIM_W'(1); state_d = S_CALC;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_d  = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
        wr_d   = (state_d == S_WR_REQ);
        busy_d = (state_d != S_IDLE);
    end

`ifdef TC_PERF_CNT_EN
    logic [P_CYC_W-1:0] cycles_q;

    // Saturating count of cycles spent with BUSY high, cleared by an accepted START.
    always_ff @(posedge I_TC_HCLK or negedge I_TC_HRESET_N) begin
        if (!I_TC_HRESET_N) begin
            cycles_q <= '0;
        end else if ((state_q == S_IDLE) && bus.I_TC_START) begin
            cycles_q <= '0;
        end else if (busy_q && (cycles_q != '1)) begin
            cycles_q <= cycles_q + P_CYC_W'(1);
        end
    end

    assign bus.O_TC_CYCLES = cycles_q;
`else
    assign bus.O_TC_CYCLES = '0;
`endif

    assign bus.O_TC_DMA_REQ   = req_q;
    assign bus.O_TC_DMA_WRITE = wr_q;
    assign bus.O_TC_DMA_ADDR  = addr_q;
    assign bus.O_TC_DMA_LEN   = len_q;
    assign bus.O_TC_CORE_GO   = go_q;
    assign bus.O_TC_BUSY      = busy_q;
    assign bus.O_TC_DONE      = done_q;
    assign bus.O_TC_ERR       = err_q;
    assign bus.O_TC_ABORTED   = abort_q;

endmodule

// File: tb/tb_rotate_tile_ctrl.sv
// Bench for rotate_tile_ctrl: pixel-rotation reference model plus directed frames.
module tb_rotate_tile_ctrl;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
    } cmd_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rotate_tile_ctrl_if #(.P_AW(32)) bus ();

    rotate_tile_ctrl #(.P_AW(32), .P_ROW_WORDS(6)) dut (
        .I_TC_HCLK     (clk),
        .I_TC_HRESET_N (rst_n),
        .bus           (bus)
    );

    cmd_t exp_q[$];
    cmd_t obs_q[$];
    int   tests = 0;
    int   fails = 0;
    int   go_cnt = 0;
    int   done_cnt = 0;
    int   done_lat = 1;
    int   cyc = 0;
    int   start_cyc = 0;
    int   first_req_lat = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic cmd_t obs_at(input int i);
        return (i < obs_q.size()) ? obs_q[i] : cmd_t'('0);
    endfunction

    // Reference: rotate the source tile's corner pixel quarter-turn by quarter-turn.
    task automatic build_model(input int w, input int h, input int deg, input int dir,
                               input logic [31:0] src, input logic [31:0] dst);
        int q, dx, dy, cw, ch, nx;
        exp_q.delete();
        q = dir ? ((4 - deg) % 4) : deg;
        for (int ty = 0; ty < h / 8; ty++) begin
            for (int tx = 0; tx < w / 8; tx++) begin
                dx = tx * 8; dy = ty * 8; cw = w; ch = h;
                for (int k = 0; k < q; k++) begin
                    nx = ch - 1 - dy; dy = dx; dx = nx;
                    nx = cw; cw = ch; ch = nx;
                end
                dx = (dx / 8) * 8; dy = (dy / 8) * 8;
                for (int r = 0; r < 8; r++)
                    exp_q.push_back({1'b0, src + 32'(3 * ((ty * 8 + r) * w + tx * 8))});
                for (int r = 0; r < 8; r++)
                    exp_q.push_back({1'b1, dst + 32'(3 * ((dy + r) * cw + dx))});
            end
        end
    endtask

    // One cycle: DMA/core responder and per-command comparison against the model.
    task automatic step();
        cmd_t a;
        @(negedge clk);
        cyc++;
        bus.I_TC_DMA_ACK = 1'b0; bus.I_TC_DMA_DONE = 1'b0; bus.I_TC_CORE_DONE = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) bus.I_TC_DMA_DONE = 1'b1;
        end
        if (bus.O_TC_CORE_GO === 1'b1) begin
            go_cnt++;
            bus.I_TC_CORE_DONE = 1'b1;
        end
        if (bus.O_TC_DMA_REQ === 1'b1) begin
            a = {bus.O_TC_DMA_WRITE, bus.O_TC_DMA_ADDR};
            if (obs_q.size() == 0 && first_req_lat < 0) first_req_lat = cyc - start_cyc + 1;
            obs_q.push_back(a);
            bus.I_TC_DMA_ACK = 1'b1;
            done_cnt = done_lat;
            chk("dma_len", 64'(bus.O_TC_DMA_LEN), 64'd6);
            if (exp_q.size() > 0) begin
                chk($sformatf("cmd%0d", obs_q.size() - 1), 64'(a), 64'(exp_q.pop_front()));
            end else begin
                tests++; fails++;
                $display("FAIL unexpected_req: got wr=%0d addr=0x%0h expected no request", a.wr, a.addr);
            end
        end
    endtask

    task automatic start_frame(input int w, input int h, input int deg, input int dir);
        bus.I_TC_WIDTH = 16'(w); bus.I_TC_HEIGHT = 16'(h);
        bus.I_TC_DEGREES = 2'(deg); bus.I_TC_DIRECTION = 1'(dir);
        bus.I_TC_SRC_BASE = 32'h1000; bus.I_TC_DST_BASE = 32'h8000;
        build_model(w, h, deg, dir, 32'h1000, 32'h8000);
        obs_q.delete(); go_cnt = 0; first_req_lat = -1;
        bus.I_TC_START = 1'b1;
        step();
        start_cyc = cyc;
        bus.I_TC_START = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 4000; i++) begin
            if (bus.O_TC_DONE || bus.O_TC_ERR || bus.O_TC_ABORTED) break;
            step();
        end
    endtask

    task automatic run_frame(input string tag, input int w, input int h, input int deg, input int dir);
        start_frame(w, h, deg, dir);
        wait_end();
        chk({tag, "_done"}, 64'(bus.O_TC_DONE), 64'd1);
        chk({tag, "_busy"}, 64'(bus.O_TC_BUSY), 64'd0);
        chk({tag, "_flags"}, 64'({bus.O_TC_ERR, bus.O_TC_ABORTED}), 64'd0);
        chk({tag, "_model_drained"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_core_go"}, 64'(go_cnt), 64'((w / 8) * (h / 8)));
        chk({tag, "_start_to_req"}, 64'(first_req_lat), 64'd3);
    endtask

    initial begin
        bus.I_TC_START = 1'b0; bus.I_TC_STOP = 1'b0; bus.I_TC_WIDTH = '0; bus.I_TC_HEIGHT = '0;
        bus.I_TC_DEGREES = '0; bus.I_TC_DIRECTION = 1'b0; bus.I_TC_SRC_BASE = '0; bus.I_TC_DST_BASE = '0;
        bus.I_TC_DMA_ACK = 1'b0; bus.I_TC_DMA_DONE = 1'b0; bus.I_TC_CORE_DONE = 1'b0;

        step(); step();
        chk("reset_outputs", 64'({bus.O_TC_DMA_REQ, bus.O_TC_DMA_WRITE, bus.O_TC_DMA_ADDR, bus.O_TC_DMA_LEN,
            bus.O_TC_CORE_GO, bus.O_TC_BUSY, bus.O_TC_DONE, bus.O_TC_ERR, bus.O_TC_ABORTED}), 64'd0);
        chk("reset_cycles", 64'(bus.O_TC_CYCLES), 64'd0);
        rst_n = 1'b1;
        step();

        // Rotation 0: reads step 3*W, tile 1 starts 24 bytes on.
        build_model(16, 8, 0, 0, 32'h1000, 32'h8000);
        chk("model_deg0_tile1_rd", 64'(exp_q[16]), 64'({1'b0, 32'h1018}));
        run_frame("deg0", 16, 8, 0, 0);
        chk("deg0_rd0", 64'(obs_at(0)), 64'({1'b0, 32'h1000}));
        chk("deg0_rd1", 64'(obs_at(1)), 64'({1'b0, 32'h1030}));
        chk("deg0_wr0", 64'(obs_at(8)), 64'({1'b1, 32'h8000}));
        chk("deg0_t1_rd0", 64'(obs_at(16)), 64'({1'b0, 32'h1018}));
        chk("deg0_t1_wr0", 64'(obs_at(24)), 64'({1'b1, 32'h8018}));
        chk("deg0_bursts", 64'(obs_q.size()), 64'd32);

        run_frame("cw90", 16, 8, 1, 0);
        chk("cw90_t0_wr0", 64'(obs_at(8)), 64'({1'b1, 32'h8000}));
        chk("cw90_t0_wr1", 64'(obs_at(9)), 64'({1'b1, 32'h8018}));
        chk("cw90_t1_wr0", 64'(obs_at(24)), 64'({1'b1, 32'h80C0}));

        build_model(16, 8, 1, 1, 32'h1000, 32'h8000);
        chk("model_ccw90_t0_wr0", 64'(exp_q[8]), 64'({1'b1, 32'h80C0}));
        run_frame("ccw90", 16, 8, 1, 1);
        chk("ccw90_t0_wr0", 64'(obs_at(8)), 64'({1'b1, 32'h80C0}));
        chk("ccw90_t1_wr0", 64'(obs_at(24)), 64'({1'b1, 32'h8000}));

        run_frame("deg180", 16, 16, 2, 0);
        run_frame("cw270", 8, 16, 3, 0);
        run_frame("ccw270", 24, 16, 3, 1);

        // Bad geometry: ERR appears two cycles after START, no request ever issued.
        for (int k = 0; k < 2; k++) begin
            start_frame((k == 0) ? 12 : 0, 8, 0, 0);
            chk($sformatf("err%0d_check_cycle", k), 64'({bus.O_TC_ERR, bus.O_TC_BUSY}), 64'd1);
            step();
            chk($sformatf("err%0d_err", k), 64'(bus.O_TC_ERR), 64'd1);
            chk($sformatf("err%0d_busy_done", k), 64'({bus.O_TC_BUSY, bus.O_TC_DONE}), 64'd0);
            step(); step();
            chk($sformatf("err%0d_no_req", k), 64'(obs_q.size()), 64'd0);
        end

        // STOP while row 3 of tile 0 is in flight: its DONE is waited for, then abort.
        done_lat = 4;
        start_frame(16, 8, 0, 0);
        for (int i = 0; i < 200; i++) begin
            if (obs_q.size() == 4) break;
            step();
        end
        step();
        bus.I_TC_STOP = 1'b1;
        step();
        bus.I_TC_STOP = 1'b0;
        chk("stop_draining", 64'({bus.O_TC_BUSY, bus.O_TC_ABORTED}), 64'b10);
        for (int i = 0; i < 30; i++) step();
        chk("stop_aborted", 64'(bus.O_TC_ABORTED), 64'd1);
        chk("stop_done_busy", 64'({bus.O_TC_DONE, bus.O_TC_BUSY}), 64'd0);
        chk("stop_no_more_req", 64'(obs_q.size()), 64'd4);
        done_lat = 1;

        // Asynchronous reset in the middle of a write burst.
        start_frame(16, 8, 0, 0);
        for (int i = 0; i < 400; i++) begin
            if (obs_q.size() >= 10) break;
            step();
        end
        chk("pre_reset_in_write", 64'(obs_at(9).wr), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({bus.O_TC_DMA_REQ, bus.O_TC_DMA_WRITE, bus.O_TC_DMA_ADDR, bus.O_TC_DMA_LEN,
            bus.O_TC_CORE_GO, bus.O_TC_BUSY, bus.O_TC_DONE, bus.O_TC_ERR, bus.O_TC_ABORTED}), 64'd0);
        chk("async_reset_cycles", 64'(bus.O_TC_CYCLES), 64'd0);
        done_cnt = 0;
        step(); step();
        rst_n = 1'b1;
        step();
        run_frame("post_reset", 16, 8, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rotate_tile_ctrl.md
Name: rotate_tile_ctrl

Overview:
- Frame-level sequencer for the pixel rotation core.
- Splits an RGB888 image (3 bytes/pixel) into 8x8-pixel tiles, scanned row-major.
- Per tile: issues 8 row-read bursts to the AHB DMA, hands the tile to the rotation core, then issues 8 row-write bursts to the rotated destination tile location.
- Sits between the register file and the DMA/core pair; raises done/error status.

Parameters:
- P_AW, 32, DMA byte address width.
- P_ROW_WORDS, 6, 32-bit words per tile row burst (8 px * 3 B / 4).

Ports:
- I_TC_HCLK  in  1  system clock; all logic on rising edge.
- I_TC_HRESET_N  in  1  asynchronous active-low reset.
- I_TC_START  in  1  1-cycle start pulse.
- I_TC_STOP  in  1  abort request.
- I_TC_WIDTH  in  16  image width in pixels.
- I_TC_HEIGHT  in  16  image height in pixels.
- I_TC_DEGREES  in  2  0=0, 1=90, 2=180, 3=270.
- I_TC_DIRECTION  in  1  1=counter-clockwise, 0=clockwise.
- I_TC_SRC_BASE  in  P_AW  source frame byte address.
- I_TC_DST_BASE  in  P_AW  destination frame byte address.
- O_TC_DMA_REQ  out  1  burst command valid.
- O_TC_DMA_WRITE  out  1  1=write burst, 0=read burst.
- O_TC_DMA_ADDR  out  P_AW  burst start byte address.
- O_TC_DMA_LEN  out  4  burst length in words, always P_ROW_WORDS.
- I_TC_DMA_ACK  in  1  command accepted.
- I_TC_DMA_DONE  in  1  burst complete pulse.
- O_TC_CORE_GO  out  1  1-cycle pulse: tile is in the input buffer, rotate it.
- I_TC_CORE_DONE  in  1  core finished filling the output buffer.
- O_TC_BUSY  out  1  frame in progress.
- O_TC_DONE  out  1  sticky frame complete.
- O_TC_ERR  out  1  sticky bad-geometry flag.
- O_TC_ABORTED  out  1  sticky stopped-by-request flag.
- O_TC_CYCLES  out  32  busy-cycle counter (optional feature).

Behaviour:
- Reset: all outputs 0; state IDLE; tile counters 0.
- States: IDLE, CHECK, CALC, RD_REQ, RD_WAIT, ROT, WR_REQ, WR_WAIT, NEXT.
- IDLE:
  - START clears DONE/ERR/ABORTED and goes to CHECK.
  - START while not IDLE is ignored.
- CHECK: if WIDTH or HEIGHT is 0, or either has bits[2:0] != 0, set ERR and return to IDLE. Otherwise latch all config inputs, set TX=W/8, TY=H/8, and go to CALC.
- Effective rotation: CCW 90 equals CW 270, and vice versa. 0 and 180 are direction-independent.
- Destination tile (dtx, dty) from source tile (tx, ty):
  - 0: (tx, ty).
  - 180: (TX-1-tx, TY-1-ty).
  - CW90: (TY-1-ty, tx).
  - CW270: (ty, TX-1-tx).
- Destination width DW = W for 0/180, H for 90/270.
- CALC (1 cycle), all arithmetic modulo 2^P_AW:
  - src_row0 = SRC_BASE + (ty*8*W + tx*8)*3.
  - dst_row0 = DST_BASE + (dty*8*DW + dtx*8)*3.
  - Row r adds r*3*W (source) or r*3*DW (destination).
- RD_REQ: REQ=1, WRITE=0, ADDR=src_row0 + r*3W. Hold REQ/ADDR stable until ACK, then go to RD_WAIT.
- RD_WAIT: on DMA_DONE, r++. If r==8, reset r to 0, pulse CORE_GO, and go to ROT; else go to RD_REQ.
- ROT: wait for CORE_DONE, then go to WR_REQ.
- WR_REQ/WR_WAIT: same as read with WRITE=1 and destination addresses. After row 8 go to NEXT.
- NEXT: tx++. On tx==TX wrap tx to 0 and ty++. On ty==TY: set DONE, BUSY=0, go to IDLE. Otherwise go to CALC.
- BUSY=1 in every state except IDLE.
- STOP, when observed outside IDLE:
  - Sets a pending flag.
  - If REQ is not yet acked, drop REQ immediately and go to IDLE with ABORTED=1.
  - In *_WAIT or ROT, finish the current burst/core handshake, then go to IDLE with ABORTED=1.
  - STOP in IDLE is ignored.
- Simultaneous events:
  - ACK and STOP in the same cycle: the burst counts as issued, so wait for its DMA_DONE.
  - DMA_DONE and STOP in the same cycle: go to IDLE.
- Reset mid-frame: immediate return to IDLE with all flags 0. No drain; the DMA is reset by the same reset.
- Latency: START to first REQ is 3 cycles (CHECK, CALC, RD_REQ).

Optional Feature:
- Macro TC_PERF_CNT_EN.
- Defined: O_TC_CYCLES clears on START and increments every cycle BUSY=1, saturating at 0xFFFFFFFF.
- Undefined: O_TC_CYCLES tied to 0 and no counter is instantiated.

Decomposition:
- Package rotate_pkg holds:
  - State encoding.
  - Degree codes P_DEG_0..P_DEG_270.
  - Tile size 8 and bytes-per-pixel 3.
- Sub-module rotate_tile_addr: combinational tile-mapping plus address computation (CALC datapath), instantiated once.

Test Plan:
- W=16,H=8,deg0, SRC=0x1000, DST=0x8000, immediate ACK/DONE:
  - First read 0x1000, rows step 48.
  - Tile1 read 0x1018.
  - Writes mirror reads at 0x8000/0x8018.
  - DONE after 32 bursts and 2 CORE_GO pulses.
- Same geometry, deg90, dir=0 (CW):
  - Tile0 writes at 0x8000, rows step 24.
  - Tile1 writes at 0x80C0.
- Same geometry, deg90, dir=1 (CCW), which is CW270:
  - Tile0 writes at 0x80C0.
  - Tile1 writes at 0x8000.
- W=12,H=8, START -> ERR=1 next-but-one cycle, no REQ, BUSY=0. W=0 gives the same result.
- STOP during RD_WAIT of tile0 row3 -> that row's DONE is honoured, no further REQ, ABORTED=1, DONE=0.
- Assert HRESET_N low asynchronously mid-write -> all outputs 0 without a clock edge; a new START runs a clean frame.
